seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Multi-cycle, parametrised ALU. Next generation of the combinational 4-bit ALU:
//  - generic data width, 8 operations
//  - iterative shift-add multiplier and restoring divider
//  - registered result/flags
//  - start/busy/done handshake
//  Sits between register-file read and write-back of the datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2); multiply/divide take WIDTH iterations
// PORTS
//  clk             in   1      single clock, all state on rising edge
//  rst             in   1      synchronous, active-high reset
//  start           in   1      request; operands/op sampled when start=1 and busy=0
//  a               in   WIDTH  operand A
//  b               in   WIDTH  operand B
//  opCode          in   3      000 add,001 mul,010 div,011 sub,100 mod,101 and,110 or,111 xor
//  ci              in   1      carry-in, used by add only
//  busy            out  1      high from accepted start until the cycle done rises
//  done            out  1      one-cycle pulse: result and flags valid
//  out             out  WIDTH  result, held until next accepted start
//  negativo        out  1      out[WIDTH-1]
//  cero            out  1      out==0
//  acarreo         out  1      carry / no-borrow
//  desbordamiento  out  1      overflow / divide-by-zero
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, out and all four flags = 0. Any cycle with rst=1
//   aborts an operation in progress; no done is produced for it.
//  FSM IDLE -> CALC -> FIN -> IDLE.
//   IDLE: start=1 latches a, b, opCode, ci. Next state:
//    - CALC for mul/div/mod
//    - FIN for all other ops
//   CALC: iteration counter 0..WIDTH-1, one step per cycle; after step WIDTH-1 -> FIN.
//   FIN: register out and flags, pulse done=1, -> IDLE.
//  Latency, start to done:
//   - add/sub/and/or/xor: 2 cycles
//   - mul/div/mod: WIDTH+2 cycles
//   - start with busy=1 is ignored; start in the cycle done=1 is accepted (done=1 in IDLE)
//  Arithmetic:
//   - add: {acarreo,out} = a+b+ci; desbordamiento = signed overflow
//   - sub: out = a-b mod 2^WIDTH (ci ignored); acarreo = (a>=b) unsigned;
//     desbordamiento = signed overflow
//   - mul: unsigned 2*WIDTH product; out = low WIDTH bits;
//     desbordamiento = (high half != 0); acarreo = 0
//   - div/mod: unsigned restoring division; div out = quotient, mod out = remainder;
//     acarreo = 0; desbordamiento = 0 when b!=0
//   - b==0 for div/mod: still WIDTH+2 cycles; desbordamiento = 1;
//     quotient = all ones, remainder = a
//   - and/or/xor: bitwise; acarreo = desbordamiento = 0
//   - negativo and cero are always derived from the final out
//  Outputs change only in FIN or on reset; stable while busy.
// TESTING (WIDTH=8)
//  1. add a=8'hFF b=8'h01 ci=1 -> done 2 cycles after start;
//     out=8'h01, acarreo=1, cero=0, desbordamiento=0
//  2. sub a=8'h80 b=8'h01 -> out=8'h7F, acarreo=1, desbordamiento=1, negativo=0;
//     sub a=5 b=5 -> out=0, cero=1, acarreo=1
//  3. mul a=8'h10 b=8'h20 -> done at cycle 10, out=8'h00, cero=1, desbordamiento=1;
//     mul 12*11 -> out=8'h84, negativo=1, desbordamiento=0
//  4. div a=200 b=7 -> out=28; mod -> out=4;
//     div a=9 b=0 -> out=8'hFF, desbordamiento=1, latency 10 cycles
//  5. start pulsed again at cycle 3 of a mul -> ignored, busy stays 1, single done;
//     back-to-back start on the done cycle -> accepted
//  6. rst=1 at cycle 5 of a div -> next cycle busy=0, done=0, out=0, all flags 0;
//     no late done pulse

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: add/sub/logic in one FIN cycle, shift-add multiply and
// restoring divide over WIDTH CALC cycles, registered result/flags with start/busy/done.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opCode,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             negativo,
  output logic             cero,
  output logic             acarreo,
  output logic             desbordamiento
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_MUL = 3'b001, OP_DIV = 3'b010, OP_SUB = 3'b011,
    OP_MOD = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111
  } op_e;

  state_e           r_state, w_next;
  op_e              r_op, w_op_in;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic             r_ci;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_neg, r_zero, r_carry, r_ovf, r_done;

  logic             w_accept, w_iterative, w_last;
  logic [WIDTH:0]   w_madd, w_shift, w_diff, w_sum;
  logic [WIDTH-1:0] w_dif, w_step_hi, w_step_lo, w_res;
  logic             w_carry, w_ovf;

  assign w_op_in     = op_e'(opCode);
  assign w_accept    = (r_state == IDLE) && start;
  assign w_iterative = (w_op_in == OP_MUL) || (w_op_in == OP_DIV) || (w_op_in == OP_MOD);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_iterative ? CALC : FIN;
      CALC:    if (w_last) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One iteration: mul accumulates into r_hi and shifts the product right through r_lo;
  // div shifts the dividend out of r_lo into the partial remainder and shifts quotient bits in.
  always_comb begin
    w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_op == OP_MUL) begin
      w_step_hi = w_madd[WIDTH:1];
      w_step_lo = {w_madd[0], r_lo[WIDTH-1:1]};
    end else if (w_diff[WIDTH]) begin
      w_step_hi = w_shift[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
    end else begin
      w_step_hi = w_diff[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    w_sum   = {1'b0, r_a} + {1'b0, r_b} + (WIDTH+1)'(r_ci);
    w_dif   = r_a - r_b;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_dif;
        w_carry = (r_a >= r_b);
        w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_MUL: begin
        w_res = r_lo;
        w_ovf = |r_hi;
      end
      // b==0 falls out of the iteration as quotient all ones, remainder a
      OP_DIV: begin
        w_res = r_lo;
        w_ovf = (r_b == '0);
      end
      OP_MOD: begin
        w_res = r_hi;
        w_ovf = (r_b == '0);
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_ci    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op  <= w_op_in;
        r_a   <= a;
        r_b   <= b;
        r_ci  <= ci;
        r_hi  <= '0;
        r_lo  <= (w_op_in == OP_MUL) ? b : a;
        r_cnt <= '0;
      end
      if (r_state == CALC) begin
        r_hi  <= w_step_hi;
        r_lo  <= w_step_lo;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == FIN) begin
        r_out   <= w_res;
        r_neg   <= w_res[WIDTH-1];
        r_zero  <= (w_res == '0);
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
        r_done  <= 1'b1;
      end
    end
  end

  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign out            = r_out;
  assign negativo       = r_neg;
  assign cero           = r_zero;
  assign acarreo        = r_carry;
  assign desbordamiento = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst, start, ci;
  logic [7:0] a, b, out;
  logic [2:0] opCode;
  logic       busy, done, negativo, cero, acarreo, desbordamiento;

  int n_checks = 0;
  int n_errors = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .opCode(opCode), .ci(ci),
    .busy(busy), .done(done), .out(out), .negativo(negativo), .cero(cero),
    .acarreo(acarreo), .desbordamiento(desbordamiento)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for done; returns the start-to-done latency in cycles.
  task automatic run_op(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                        input logic vci, output int lat, output bit stable_ok);
    logic [7:0] held;
    held      = out;
    stable_ok = 1'b1;
    opCode = op; a = va; b = vb; ci = vci; start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 50) begin
      if (!busy || out !== held) stable_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  int lat;
  bit ok;
  int n_done;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; opCode = '0; ci = 1'b0;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out", out, 0);
    chk("reset_flags", {negativo, cero, acarreo, desbordamiento}, 4'b0000);
    rst = 1'b0;
    tick();

    run_op(3'b000, 8'hFF, 8'h01, 1'b1, lat, ok);
    chk("add_lat", lat, 2);
    chk("add_stable", ok, 1);
    chk("add_out", out, 8'h01);
    chk("add_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b0010);
    chk("add_busy_on_done", busy, 0);

    tick();
    chk("done_single_pulse", done, 0);

    run_op(3'b011, 8'h80, 8'h01, 1'b1, lat, ok);
    chk("sub_ovf_out", out, 8'h7F);
    chk("sub_ovf_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b0011);
    run_op(3'b011, 8'd5, 8'd5, 1'b0, lat, ok);
    chk("sub_eq_out", out, 8'h00);
    chk("sub_eq_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b0110);
    run_op(3'b011, 8'd3, 8'd5, 1'b0, lat, ok);
    chk("sub_borrow_out", out, 8'hFE);
    chk("sub_borrow_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b1000);

    run_op(3'b001, 8'h10, 8'h20, 1'b0, lat, ok);
    chk("mul_lat", lat, 10);
    chk("mul_stable", ok, 1);
    chk("mul_hi_out", out, 8'h00);
    chk("mul_hi_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b0101);
    run_op(3'b001, 8'd12, 8'd11, 1'b0, lat, ok);
    chk("mul_out", out, 8'h84);
    chk("mul_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b1000);
    run_op(3'b001, 8'hFF, 8'hFF, 1'b0, lat, ok);
    chk("mul_max_out", out, 8'h01);
    chk("mul_max_ovf", desbordamiento, 1);

    run_op(3'b010, 8'd200, 8'd7, 1'b0, lat, ok);
    chk("div_lat", lat, 10);
    chk("div_out", out, 8'd28);
    chk("div_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b0000);
    run_op(3'b100, 8'd200, 8'd7, 1'b0, lat, ok);
    chk("mod_out", out, 8'd4);
    run_op(3'b010, 8'd9, 8'd0, 1'b0, lat, ok);
    chk("div0_lat", lat, 10);
    chk("div0_out", out, 8'hFF);
    chk("div0_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b1001);
    run_op(3'b100, 8'd9, 8'd0, 1'b0, lat, ok);
    chk("mod0_out", out, 8'd9);
    chk("mod0_ovf", desbordamiento, 1);
    run_op(3'b010, 8'hFF, 8'h01, 1'b0, lat, ok);
    chk("div_by1_out", out, 8'hFF);

    run_op(3'b101, 8'hF0, 8'h3C, 1'b1, lat, ok);
    chk("and_lat", lat, 2);
    chk("and_out", out, 8'h30);
    chk("and_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b0000);
    run_op(3'b110, 8'hF0, 8'h3C, 1'b0, lat, ok);
    chk("or_out", out, 8'hFC);
    run_op(3'b111, 8'hF0, 8'h3C, 1'b0, lat, ok);
    chk("xor_out", out, 8'hCC);
    chk("xor_neg", negativo, 1);
    run_op(3'b000, 8'h7F, 8'h00, 1'b1, lat, ok);
    chk("add_ovf_out", out, 8'h80);
    chk("add_ovf_flags_NZCV", {negativo, cero, acarreo, desbordamiento}, 4'b1001);

    // start re-asserted mid-multiply must be ignored
    tick();
    opCode = 3'b001; a = 8'd12; b = 8'd11; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    n_done = 0;
    tick(); lat++;
    opCode = 3'b000; a = 8'd1; b = 8'd1; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    chk("ignored_start_busy", busy, 1);
    while (!done && lat < 50) begin
      tick();
      lat++;
    end
    chk("ignored_start_lat", lat, 10);
    chk("ignored_start_out", out, 8'h84);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("ignored_start_no_extra_done", n_done, 0);

    // back-to-back: start on the done cycle
    run_op(3'b000, 8'd3, 8'd4, 1'b0, lat, ok);
    run_op(3'b000, 8'd10, 8'd20, 1'b0, lat, ok);
    chk("b2b_lat", lat, 2);
    chk("b2b_out", out, 8'd30);
    run_op(3'b001, 8'd7, 8'd9, 1'b0, lat, ok);
    chk("b2b_mul_lat", lat, 10);
    chk("b2b_mul_out", out, 8'd63);

    // reset mid-divide
    tick();
    opCode = 3'b010; a = 8'd200; b = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", {negativo, cero, acarreo, desbordamiento}, 4'b0000);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    chk("rst_no_late_done", n_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
